// File: rtl/oflow_conflict_resolve_ctrl.sv
// oflow_conflict_resolve_ctrl
// Runs duplicate-ID conflict resolution over the score board after a frame's
// rows are registered. Each cycle it reads one row through the CR read port.
// When two rows hold the same ID, the loser's pointer is moved to its second
// choice. A loser that is already on its second choice is marked unmatched.
// Passes repeat until a pass finds no conflict or MAX_PASSES is reached.
// Optional build macro OFLOW_CR_STATS_EN adds the conflict_cnt/cr_cycles outputs.
//
// state  | meaning
// IDLE   | waiting for start_cr
// LOAD_I | read row i, latch its current ID and score
// CMP_J  | read row j, compare it against the latched row i
// FLIP   | write the loser's pointer, or mark the loser unmatched
// DONE   | pulse done_cr, drop busy_cr, return to IDLE
module oflow_conflict_resolve_ctrl #(
    parameter int MAX_ROWS   = 32,
    parameter int ROW_LEN    = 5,
    parameter int SCORE_LEN  = 16,
    parameter int ID_LEN     = 12,
    parameter int MAX_PASSES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_cr,
    input  logic [ROW_LEN:0]     num_rows,
    output logic [ROW_LEN-1:0]   row_sel_from_cr,
    input  logic [SCORE_LEN-1:0] score_to_cr,
    input  logic [ID_LEN-1:0]    id_to_cr,
    output logic                 write_to_pointer,
    output logic [ROW_LEN-1:0]   row_to_change,
    output logic                 data_from_cr,
    output logic [MAX_ROWS-1:0]  unmatched,
    output logic                 busy_cr,
    output logic                 done_cr
`ifdef OFLOW_CR_STATS_EN
    ,
    output logic [7:0]           conflict_cnt,
    output logic [15:0]          cr_cycles
`endif
);

    localparam int PASS_W = $clog2(MAX_PASSES + 1);
    localparam logic [ROW_LEN:0] ONE = (ROW_LEN+1)'(1);
    localparam logic [ROW_LEN:0] TWO = (ROW_LEN+1)'(2);

    typedef enum logic [2:0] {IDLE, LOAD_I, CMP_J, FLIP, DONE} state_t;

    state_t               state;
    logic [ROW_LEN:0]     n_rows;
    logic [ROW_LEN:0]     i;
    logic [ROW_LEN:0]     j;
    logic [ID_LEN-1:0]    id_i;
    logic [SCORE_LEN-1:0] score_i;
    logic                 dirty;
    logic [PASS_W-1:0]    pass;
    logic [MAX_ROWS-1:0]  ptr;
    logic [ROW_LEN-1:0]   loser;

    logic [ROW_LEN-1:0]   i_idx;
    logic [ROW_LEN-1:0]   j_idx;
    logic                 conflict;
    logic [ROW_LEN-1:0]   loser_c;
    logic                 j_last;
    logic                 pass_last;
    logic                 rerun;
    state_t               re_state;
    logic [ROW_LEN:0]     re_i;
    logic [ROW_LEN:0]     re_j;
    logic [PASS_W-1:0]    re_pass;
    logic                 re_dirty;

    // Compare decode plus the "row i finished" next values shared by three states
    always_comb begin
        i_idx           = i[ROW_LEN-1:0];
        j_idx           = j[ROW_LEN-1:0];
        row_sel_from_cr = (state == CMP_J) ? j_idx : i_idx;
        conflict        = (id_i != '0) && (id_to_cr != '0) && !unmatched[j_idx]
                          && (id_to_cr == id_i);
        // Ties go against the higher index row j
        loser_c         = (score_to_cr < score_i) ? i_idx : j_idx;
        j_last          = (j + ONE) >= n_rows;
        pass_last       = (i + TWO) >= n_rows;
        // A FLIP in this very cycle makes the pass dirty even though dirty is not yet set
        rerun           = (dirty || (state == FLIP)) && ((int'(pass) + 1) < MAX_PASSES);
        re_state        = LOAD_I;
        re_i            = i + ONE;
        re_j            = i + TWO;
        re_pass         = pass;
        re_dirty        = dirty || (state == FLIP);
        if (pass_last) begin
            if (rerun) begin
                re_i     = '0;
                re_j     = ONE;
                re_pass  = pass + PASS_W'(1);
                re_dirty = 1'b0;
            end else begin
                re_state = DONE;
            end
        end
    end

    // Sequencer with registered pointer-write, busy and done outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            n_rows           <= '0;
            i                <= '0;
            j                <= '0;
            id_i             <= '0;
            score_i          <= '0;
            dirty            <= 1'b0;
            pass             <= '0;
            ptr              <= '0;
            loser            <= '0;
            unmatched        <= '0;
            write_to_pointer <= 1'b0;
            row_to_change    <= '0;
            data_from_cr     <= 1'b0;
            busy_cr          <= 1'b0;
            done_cr          <= 1'b0;
        end else begin
            done_cr <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_cr) begin
                        n_rows    <= num_rows;
                        ptr       <= '0;
                        unmatched <= '0;
                        i         <= '0;
                        j         <= ONE;
                        pass      <= '0;
                        dirty     <= 1'b0;
                        busy_cr   <= 1'b1;
                        state     <= (num_rows <= ONE) ? DONE : LOAD_I;
                    end
                end
                LOAD_I: begin
                    id_i    <= id_to_cr;
                    score_i <= score_to_cr;
                    if ((id_to_cr == '0) || unmatched[i_idx]) begin
                        state <= re_state;
                        i     <= re_i;
                        j     <= re_j;
                        pass  <= re_pass;
                        dirty <= re_dirty;
                    end else begin
                        state <= CMP_J;
                    end
                end
                CMP_J: begin
                    if (conflict) begin
                        loser <= loser_c;
                        state <= FLIP;
                        if (!ptr[loser_c]) begin
                            write_to_pointer <= 1'b1;
                            row_to_change    <= loser_c;
                            data_from_cr     <= 1'b1;
                        end
                    end else if (j_last) begin
                        state <= re_state;
                        i     <= re_i;
                        j     <= re_j;
                        pass  <= re_pass;
                        dirty <= re_dirty;
                    end else begin
                        j <= j + ONE;
                    end
                end
                FLIP: begin
                    write_to_pointer <= 1'b0;
                    data_from_cr     <= 1'b0;
                    dirty            <= 1'b1;
                    if (write_to_pointer) begin
                        ptr[loser] <= 1'b1;
                    end else begin
                        unmatched[loser] <= 1'b1;
                    end
                    if (loser == i_idx) begin
                        // Row i moved to its second choice: reload it and rescan from i+1
                        j     <= i + ONE;
                        state <= LOAD_I;
                    end else if (j_last) begin
                        state <= re_state;
                        i     <= re_i;
                        j     <= re_j;
                        pass  <= re_pass;
                        dirty <= re_dirty;
                    end else begin
                        j     <= j + ONE;
                        state <= CMP_J;
                    end
                end
                DONE: begin
                    busy_cr <= 1'b0;
                    done_cr <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef OFLOW_CR_STATS_EN
    // Frame statistics; cr_cycles starts at 2 because both the start_cr cycle
    // and the done_cr cycle (spent in IDLE) belong to the measured interval
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_cnt <= '0;
            cr_cycles    <= '0;
        end else if ((state == IDLE) && start_cr) begin
            conflict_cnt <= '0;
            cr_cycles    <= 16'd2;
        end else if (state != IDLE) begin
            if (cr_cycles != 16'hFFFF) begin
                cr_cycles <= cr_cycles + 16'd1;
            end
            if ((state == CMP_J) && conflict && (conflict_cnt != 8'hFF)) begin
                conflict_cnt <= conflict_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_oflow_conflict_resolve_ctrl.sv
// Testbench for oflow_conflict_resolve_ctrl: behavioural score board, a
// frame-level reference model feeding expectation queues, and a monitor that
// checks pointer writes and completions as the DUT presents them.
module tb_oflow_conflict_resolve_ctrl;

    localparam int MAX_ROWS   = 32;
    localparam int ROW_LEN    = 5;
    localparam int SCORE_LEN  = 16;
    localparam int ID_LEN     = 12;
    localparam int MAX_PASSES = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start_cr = 1'b0;
    logic                 frame_start = 1'b0;
    logic [ROW_LEN:0]     num_rows = '0;
    logic [ROW_LEN-1:0]   row_sel_from_cr;
    logic [SCORE_LEN-1:0] score_to_cr;
    logic [ID_LEN-1:0]    id_to_cr;
    logic                 write_to_pointer;
    logic [ROW_LEN-1:0]   row_to_change;
    logic                 data_from_cr;
    logic [MAX_ROWS-1:0]  unmatched;
    logic                 busy_cr;
    logic                 done_cr;

    // Score board contents: first/second choice per row plus its pointer
    logic [ID_LEN-1:0]    sb_id1 [MAX_ROWS];
    logic [ID_LEN-1:0]    sb_id2 [MAX_ROWS];
    logic [SCORE_LEN-1:0] sb_sc1 [MAX_ROWS];
    logic [SCORE_LEN-1:0] sb_sc2 [MAX_ROWS];
    logic [MAX_ROWS-1:0]  sb_ptr = '0;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    typedef struct {
        logic [MAX_ROWS-1:0] um;
        int                  at_cyc;
    } done_t;

    int    wq[$];
    done_t dq[$];

    oflow_conflict_resolve_ctrl #(
        .MAX_ROWS(MAX_ROWS), .ROW_LEN(ROW_LEN), .SCORE_LEN(SCORE_LEN),
        .ID_LEN(ID_LEN), .MAX_PASSES(MAX_PASSES)
    ) dut (
        .clk(clk),
        .reset(rst),
        .start_cr(start_cr),
        .num_rows(num_rows),
        .row_sel_from_cr(row_sel_from_cr),
        .score_to_cr(score_to_cr),
        .id_to_cr(id_to_cr),
        .write_to_pointer(write_to_pointer),
        .row_to_change(row_to_change),
        .data_from_cr(data_from_cr),
        .unmatched(unmatched),
        .busy_cr(busy_cr),
        .done_cr(done_cr)
    );

    always #5 clk = ~clk;

    always_comb begin
        id_to_cr    = sb_ptr[row_sel_from_cr] ? sb_id2[row_sel_from_cr] : sb_id1[row_sel_from_cr];
        score_to_cr = sb_ptr[row_sel_from_cr] ? sb_sc2[row_sel_from_cr] : sb_sc1[row_sel_from_cr];
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (frame_start) sb_ptr <= '0;
        else if (write_to_pointer) sb_ptr[row_to_change] <= data_from_cr;
    end

    task automatic set_row(input int r, input int id1, input int sc1, input int id2, input int sc2);
        sb_id1[r] = ID_LEN'(id1);
        sb_sc1[r] = SCORE_LEN'(sc1);
        sb_id2[r] = ID_LEN'(id2);
        sb_sc2[r] = SCORE_LEN'(sc2);
    endtask

    // Frame-level resolution: expected writes go to wq, returns state-cycle count and unmatched set
    task automatic run_model(input int n, output int states, output logic [MAX_ROWS-1:0] um_o);
        logic [MAX_ROWS-1:0]  p;
        logic [MAX_ROWS-1:0]  um;
        logic [ID_LEN-1:0]    idi, idj;
        logic [SCORE_LEN-1:0] sci, scj;
        int pass, i, loser;
        bit dirty, restart, go;
        p = '0;
        um = '0;
        states = 1;
        if (n > 1) begin
            pass = 0;
            go = 1;
            while (go) begin
                dirty = 0;
                i = 0;
                while (i + 1 < n) begin
                    states++;
                    idi = p[i] ? sb_id2[i] : sb_id1[i];
                    sci = p[i] ? sb_sc2[i] : sb_sc1[i];
                    restart = 0;
                    if (idi != 0 && !um[i]) begin
                        for (int j = i + 1; j < n && !restart; j++) begin
                            states++;
                            idj = p[j] ? sb_id2[j] : sb_id1[j];
                            scj = p[j] ? sb_sc2[j] : sb_sc1[j];
                            if (idj != 0 && !um[j] && idj == idi) begin
                                states++;
                                dirty = 1;
                                loser = (scj < sci) ? i : j;
                                if (!p[loser]) begin
                                    p[loser] = 1'b1;
                                    wq.push_back(loser);
                                end else begin
                                    um[loser] = 1'b1;
                                end
                                if (loser == i) restart = 1;
                            end
                        end
                    end
                    if (!restart) i++;
                end
                if (dirty && pass + 1 < MAX_PASSES) pass++;
                else go = 0;
            end
        end
        um_o = um;
    endtask

    task automatic monitor();
        done_t e;
        int    r;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (write_to_pointer) begin
                    checks++;
                    if (wq.size() == 0) begin
                        errors++;
                        $display("FAIL write_unexpected: row_to_change=%0d at cycle %0d, no write expected", row_to_change, cyc);
                    end else begin
                        r = wq.pop_front();
                        if (int'(row_to_change) != r) begin
                            errors++;
                            $display("FAIL write_row: got %0d expected %0d (cycle %0d)", row_to_change, r, cyc);
                        end
                    end
                    checks++;
                    if (data_from_cr !== 1'b1) begin
                        errors++;
                        $display("FAIL write_data: got %0b expected 1", data_from_cr);
                    end
                end
                if (done_cr) begin
                    done_cnt++;
                    checks++;
                    if (dq.size() == 0) begin
                        errors++;
                        $display("FAIL done_unexpected: done_cr at cycle %0d with no frame pending", cyc);
                    end else begin
                        e = dq.pop_front();
                        checks++;
                        if (unmatched !== e.um) begin
                            errors++;
                            $display("FAIL done_unmatched: got %h expected %h", unmatched, e.um);
                        end
                        checks++;
                        if (cyc != e.at_cyc) begin
                            errors++;
                            $display("FAIL done_latency: done at cycle %0d expected %0d", cyc, e.at_cyc);
                        end
                    end
                    checks++;
                    if (busy_cr !== 1'b0) begin
                        errors++;
                        $display("FAIL done_busy: busy_cr=%0b expected 0 with done_cr", busy_cr);
                    end
                    checks++;
                    if (wq.size() != 0) begin
                        errors++;
                        $display("FAIL missing_writes: %0d expected writes not seen before done", wq.size());
                    end
                end
            end
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (write_to_pointer !== 1'b0 || row_to_change !== '0 || data_from_cr !== 1'b0 ||
            unmatched !== '0 || busy_cr !== 1'b0 || done_cr !== 1'b0 || row_sel_from_cr !== '0) begin
            errors++;
            $display("FAIL %s: wr=%b row=%0d data=%b um=%h busy=%b done=%b sel=%0d expected all 0",
                     name, write_to_pointer, row_to_change, data_from_cr, unmatched, busy_cr, done_cr, row_sel_from_cr);
        end
    endtask

    task automatic recover();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wq.delete();
        dq.delete();
    endtask

    task automatic run_frame(input int n, input bit poke);
        int                  states, d0, budget;
        logic [MAX_ROWS-1:0] um;
        done_t               e;
        run_model(n, states, um);
        @(negedge clk);
        e.um = um;
        e.at_cyc = cyc + states + 1;
        dq.push_back(e);
        d0 = done_cnt;
        num_rows = (ROW_LEN+1)'(n);
        start_cr = 1'b1;
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        start_cr = 1'b0;
        frame_start = 1'b0;
        num_rows = (ROW_LEN+1)'($urandom_range(0, MAX_ROWS));
        checks++;
        if (busy_cr !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: got %0b expected 1 (n=%0d)", busy_cr, n);
        end
        if (poke && states > 8) begin
            @(negedge clk);
            @(negedge clk);
            start_cr = 1'b1;
            @(posedge clk);
            #1;
            start_cr = 1'b0;
        end
        budget = 0;
        while (done_cnt == d0 && budget < 6000) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL done_timeout: no done_cr within %0d cycles (n=%0d)", budget, n);
            recover();
        end
    endtask

    task automatic stimulus();
        int n, idr;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_state");
        rst = 1'b0;
        @(negedge clk);

        // Four distinct IDs: single clean pass
        set_row(0, 5, 1, 0, 0); set_row(1, 6, 2, 0, 0);
        set_row(2, 7, 3, 0, 0); set_row(3, 8, 4, 0, 0);
        run_frame(4, 0);

        // Duplicate ID, row 1 better: row 0 flips
        set_row(0, 9, 10, 11, 20); set_row(1, 9, 3, 12, 20);
        run_frame(2, 0);

        // Equal scores: higher index loses
        set_row(0, 4, 7, 13, 9); set_row(1, 4, 7, 14, 9);
        run_frame(2, 0);

        // Same ID on both choices: flip, then unmatched with no second write
        set_row(0, 3, 2, 3, 9); set_row(1, 3, 5, 3, 8);
        run_frame(2, 0);

        // Degenerate frame sizes
        run_frame(1, 0);
        run_frame(0, 0);

        // Reset in the middle of a scan, then a normal frame
        set_row(0, 5, 1, 0, 0); set_row(1, 6, 2, 0, 0);
        set_row(2, 7, 3, 0, 0); set_row(3, 8, 4, 0, 0);
        @(negedge clk);
        num_rows = 6'd4;
        start_cr = 1'b1;
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        start_cr = 1'b0;
        frame_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_idle_outputs("reset_mid_scan");
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_idle_outputs("idle_after_reset");
        set_row(0, 9, 10, 11, 20); set_row(1, 9, 3, 12, 20);
        run_frame(2, 0);

        // Randomised frames, small ID alphabet to force conflicts and ties
        for (int f = 0; f < 40; f++) begin
            n = (f % 13 == 12) ? MAX_ROWS : $urandom_range(0, 9);
            idr = (n == MAX_ROWS) ? 20 : 4;
            for (int r = 0; r < MAX_ROWS; r++) begin
                set_row(r, $urandom_range(0, idr), $urandom_range(0, 5),
                        $urandom_range(0, idr), $urandom_range(0, 5));
            end
            run_frame(n, f % 3 == 0);
        end

        repeat (3) @(negedge clk);
        checks++;
        if (wq.size() != 0 || dq.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations: writes=%0d dones=%0d expected 0", wq.size(), dq.size());
        end
    endtask

    initial begin
        fork
            monitor();
            stimulus();
        join_any
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
